ram_1rw_nr_clr: RTL

Parametrised single-clock RAM with one read/write port (A) and NRD independent read-only ports (B), a selectable read-during-write policy, an optional output pipeline stage and per-port read-valid flags. After reset, and on request, a built-in clear engine writes CLEAR_VAL to every word before accepting traffic. It is the next-generation replacement for the fixed 64x16, one-read/write-plus-one-read dual-port RAM. It serves as the generic on-chip buffer for multi-reader datapaths.

---
 rtl/ram_1rw_nr_clr.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/ram_1rw_nr_clr.sv
// ram_1rw_nr_clr: single-clock RAM with one read/write port (A) and NRD
// read-only ports (B), selectable read-during-write policy, optional output
// register and a clear engine that fills every word with CLEAR_VAL after
// reset and on clr_req.
//
// Handshake: there is no back-pressure. A request on port A (ena) or port
// B[i] (enb[i]) is accepted on the rising edge that samples it only while the
// RAM is ready (init_done=1) and clr_req is low; an accepted read produces a
// single-cycle valid pulse together with its data 1 (OUT_REG=0) or 2
// (OUT_REG=1) edges later. Requests that are not accepted are dropped.
// init_done mirrors the controller state (1 = READY, 0 = CLEAR).
module ram_1rw_nr_clr #(
    parameter int                DATA_W    = 16,
    parameter int                ADDR_W    = 6,
    parameter int                NRD       = 2,
    parameter int                RDW_MODE  = 0,
    parameter int                OUT_REG   = 0,
    parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr_req,
    output logic                     init_done,
    input  logic                     ena,
    input  logic                     wea,
    input  logic [ADDR_W-1:0]        addra,
    input  logic [DATA_W-1:0]        dia,
    output logic [DATA_W-1:0]        doa,
    output logic                     doa_valid,
    input  logic [NRD-1:0]           enb,
    input  logic [NRD*ADDR_W-1:0]    addrb,
    output logic [NRD*DATA_W-1:0]    dob,
    output logic [NRD-1:0]           dob_valid
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t                      state_q, state_d;
    logic [ADDR_W-1:0]           clr_addr_q, clr_addr_d;
    logic                        init_done_q, init_done_d;

    logic [DATA_W-1:0]           mem [DEPTH];
    logic                        mem_we;
    logic [ADDR_W-1:0]           mem_waddr;
    logic [DATA_W-1:0]           mem_wdata;

    logic [NRD-1:0][ADDR_W-1:0]  addrb_v;

    // Raw read results, valid in the cycle the request is sampled
    logic                        rva;
    logic [DATA_W-1:0]           rda;
    logic [NRD-1:0]              rvb;
    logic [NRD-1:0][DATA_W-1:0]  rdb;

    // Optional first pipeline stage (only used when OUT_REG=1)
    logic                        s1_va_q, s1_va_d;
    logic [DATA_W-1:0]           s1_doa_q, s1_doa_d;
    logic [NRD-1:0]              s1_vb_q, s1_vb_d;
    logic [NRD-1:0][DATA_W-1:0]  s1_dob_q, s1_dob_d;

    // Output registers
    logic                        doa_valid_q, doa_valid_d;
    logic [DATA_W-1:0]           doa_q, doa_d;
    logic [NRD-1:0]              dob_valid_q, dob_valid_d;
    logic [NRD-1:0][DATA_W-1:0]  dob_q, dob_d;

    logic                        acc_ok;
    logic                        wr_a;

    assign addrb_v = addrb;

    // Accesses are only honoured in READY, and a clear request drops them
    assign acc_ok = (state_q == ST_READY) && !clr_req;
    assign wr_a   = acc_ok && ena && wea;

    // Controller next state and the single memory write port mux
    always_comb begin
        state_d     = state_q;
        clr_addr_d  = clr_addr_q;
        init_done_d = init_done_q;
        mem_we      = 1'b0;
        mem_waddr   = addra;
        mem_wdata   = dia;
        case (state_q)
            ST_CLEAR: begin
                // clr_req is ignored here: the sweep is never restarted
                mem_we    = 1'b1;
                mem_waddr = clr_addr_q;
                mem_wdata = CLEAR_VAL;
                if (&clr_addr_q) begin
                    state_d     = ST_READY;
                    init_done_d = 1'b1;
                    clr_addr_d  = '0;
                end else begin
                    clr_addr_d  = clr_addr_q + ADDR_W'(1);
                end
            end
            ST_READY: begin
                if (clr_req) begin
                    state_d     = ST_CLEAR;
                    init_done_d = 1'b0;
                    clr_addr_d  = '0;
                end else begin
                    mem_we = wr_a;
                end
            end
            default: begin
                state_d     = ST_CLEAR;
                init_done_d = 1'b0;
                clr_addr_d  = '0;
            end
        endcase
    end

    // Controller registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_CLEAR;
            clr_addr_q  <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_addr_q  <= clr_addr_d;
            init_done_q <= init_done_d;
        end
    end

    // Storage array; contents are not reset, the clear engine defines them
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Read data selection; the array read is the pre-write word, so
    // read-first falls out naturally and write-first bypasses dia
    always_comb begin
        rva = acc_ok && ena;
        rda = ((RDW_MODE != 0) && wea) ? dia : mem[addra];
        for (int i = 0; i < NRD; i++) begin
            rvb[i] = acc_ok && enb[i];
            rdb[i] = ((RDW_MODE != 0) && wr_a && (addra == addrb_v[i]))
                     ? dia : mem[addrb_v[i]];
        end
    end

    // Pipeline and output next-state; data registers hold when not loaded
    always_comb begin
        s1_va_d     = rva;
        s1_doa_d    = rva ? rda : s1_doa_q;
        s1_vb_d     = rvb;
        s1_dob_d    = s1_dob_q;
        doa_valid_d = 1'b0;
        doa_d       = doa_q;
        dob_valid_d = '0;
        dob_d       = dob_q;
        for (int i = 0; i < NRD; i++) begin
            if (rvb[i]) begin
                s1_dob_d[i] = rdb[i];
            end
        end
        if (OUT_REG != 0) begin
            // Stage 2 is fed from stage 1, so in-flight reads finish even
            // when a clear request arrives
            doa_valid_d = s1_va_q;
            if (s1_va_q) begin
                doa_d = s1_doa_q;
            end
            dob_valid_d = s1_vb_q;
            for (int i = 0; i < NRD; i++) begin
                if (s1_vb_q[i]) begin
                    dob_d[i] = s1_dob_q[i];
                end
            end
        end else begin
            doa_valid_d = rva;
            if (rva) begin
                doa_d = rda;
            end
            dob_valid_d = rvb;
            for (int i = 0; i < NRD; i++) begin
                if (rvb[i]) begin
                    dob_d[i] = rdb[i];
                end
            end
        end
    end

    // Pipeline and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_va_q     <= 1'b0;
            s1_doa_q    <= '0;
            s1_vb_q     <= '0;
            s1_dob_q    <= '0;
            doa_valid_q <= 1'b0;
            doa_q       <= '0;
            dob_valid_q <= '0;
            dob_q       <= '0;
        end else begin
            s1_va_q     <= s1_va_d;
            s1_doa_q    <= s1_doa_d;
            s1_vb_q     <= s1_vb_d;
            s1_dob_q    <= s1_dob_d;
            doa_valid_q <= doa_valid_d;
            doa_q       <= doa_d;
            dob_valid_q <= dob_valid_d;
            dob_q       <= dob_d;
        end
    end

    assign init_done = init_done_q;
    assign doa       = doa_q;
    assign doa_valid = doa_valid_q;
    assign dob       = dob_q;
    assign dob_valid = dob_valid_q;

endmodule
